ysyx_23060077_riscv_axi_arbiter: RTL and testbench



---
 rtl/ysyx_23060077_riscv_axi_pkg.sv | 21 ++
 rtl/ysyx_23060077_riscv_axi_rr_arb2.sv | 16 +
 rtl/ysyx_23060077_riscv_axi_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ysyx_23060077_riscv_axi_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_riscv_axi_pkg.sv
// Shared AXI-lite widths and arbiter state encodings for the IFU/LSU -> SRAM path.
package ysyx_23060077_riscv_axi_pkg;
  localparam int AXI_ADDR_WIDTH         = 32;
  localparam int AXI_DATA_WIDTH         = 32;
  localparam int AXI_STRB_WIDTH         = 4;
  localparam int AXI_RESP_WIDTH         = 2;
  localparam int AXI_PORT_WIDTH         = 3;
  localparam int AXI_RD_ARB_STATE_WIDTH = 2;
  localparam int AXI_WR_ARB_STATE_WIDTH = 1;

  typedef enum logic [AXI_RD_ARB_STATE_WIDTH-1:0] {
    RD_IDLE = 2'd0,
    RD_M0   = 2'd1,
    RD_M1   = 2'd2
  } rd_state_e;

  typedef enum logic [AXI_WR_ARB_STATE_WIDTH-1:0] {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_e;
endpackage

// File: rtl/ysyx_23060077_riscv_axi_rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time is chosen.
module ysyx_23060077_riscv_axi_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/ysyx_23060077_riscv_axi_arbiter.sv
// IFU (m0, read-only) + LSU (m1) onto a single AXI-lite SRAM slave.
// Reads are round-robin with a grant held for a whole transaction; writes come only from the LSU.
module ysyx_23060077_riscv_axi_arbiter
  import ysyx_23060077_riscv_axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int STRB_W = AXI_STRB_WIDTH,
  parameter int RESP_W = AXI_RESP_WIDTH,
  parameter int PORT_W = AXI_PORT_WIDTH
) (
  input  logic              aclk,
  input  logic              areset,
  // m0: IFU
  input  logic              m0_ar_valid_i,
  output logic              m0_ar_ready_o,
  input  logic [PORT_W-1:0] m0_ar_port_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_r_valid_o,
  input  logic              m0_r_ready_i,
  output logic [RESP_W-1:0] m0_r_resp_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  // m1: LSU
  input  logic              m1_ar_valid_i,
  output logic              m1_ar_ready_o,
  input  logic [PORT_W-1:0] m1_ar_port_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_r_valid_o,
  input  logic              m1_r_ready_i,
  output logic [RESP_W-1:0] m1_r_resp_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  input  logic              m1_aw_valid_i,
  output logic              m1_aw_ready_o,
  input  logic [PORT_W-1:0] m1_aw_port_i,
  input  logic [ADDR_W-1:0] m1_aw_addr_i,
  input  logic              m1_w_valid_i,
  output logic              m1_w_ready_o,
  input  logic [STRB_W-1:0] m1_w_strb_i,
  input  logic [DATA_W-1:0] m1_w_data_i,
  output logic              m1_b_valid_o,
  input  logic              m1_b_ready_i,
  output logic [RESP_W-1:0] m1_b_resp_o,
  // slave
  output logic              s_aw_valid_o,
  input  logic              s_aw_ready_i,
  output logic [PORT_W-1:0] s_aw_port_o,
  output logic [ADDR_W-1:0] s_aw_addr_o,
  output logic              s_w_valid_o,
  input  logic              s_w_ready_i,
  output logic [STRB_W-1:0] s_w_strb_o,
  output logic [DATA_W-1:0] s_w_data_o,
  input  logic              s_b_valid_i,
  output logic              s_b_ready_o,
  input  logic [RESP_W-1:0] s_b_resp_i,
  output logic              s_ar_valid_o,
  input  logic              s_ar_ready_i,
  output logic [PORT_W-1:0] s_ar_port_o,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_r_valid_i,
  output logic              s_r_ready_o,
  input  logic [RESP_W-1:0] s_r_resp_i,
  input  logic [DATA_W-1:0] s_r_data_i
);
  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      last_grant_q, last_grant_d;
  logic      ar_done_q, ar_done_d;
  logic      aw_done_q, aw_done_d;
  logic      w_done_q, w_done_d;
  logic [1:0] gnt;

  ysyx_23060077_riscv_axi_rr_arb2 u_rr_arb2 (
    .req_i        ({m1_ar_valid_i, m0_ar_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Read path: route everything from the owner; the other master sees all-zero.
  logic rd_act, rd_m1, m0_own, m1_own, ar_open;
  logic m_ar_valid, m_r_ready;
  assign rd_act     = (rd_state_q != RD_IDLE);
  assign rd_m1      = (rd_state_q == RD_M1);
  assign m0_own     = (rd_state_q == RD_M0);
  assign m1_own     = rd_m1;
  assign ar_open    = rd_act & ~ar_done_q;
  assign m_ar_valid = rd_m1 ? m1_ar_valid_i : m0_ar_valid_i;
  assign m_r_ready  = rd_m1 ? m1_r_ready_i  : m0_r_ready_i;

  assign s_ar_valid_o  = ar_open & m_ar_valid;
  assign s_ar_port_o   = m1_own ? m1_ar_port_i : (m0_own ? m0_ar_port_i : '0);
  assign s_ar_addr_o   = m1_own ? m1_ar_addr_i : (m0_own ? m0_ar_addr_i : '0);
  assign s_r_ready_o   = rd_act & m_r_ready;
  assign m0_ar_ready_o = m0_own & ar_open & s_ar_ready_i;
  assign m1_ar_ready_o = m1_own & ar_open & s_ar_ready_i;
  assign m0_r_valid_o  = m0_own & s_r_valid_i;
  assign m1_r_valid_o  = m1_own & s_r_valid_i;
  assign m0_r_resp_o   = m0_own ? s_r_resp_i : '0;
  assign m1_r_resp_o   = m1_own ? s_r_resp_i : '0;
  assign m0_r_data_o   = m0_own ? s_r_data_i : '0;
  assign m1_r_data_o   = m1_own ? s_r_data_i : '0;

  always_comb begin
    rd_state_d   = rd_state_q;
    last_grant_d = last_grant_q;
    ar_done_d    = ar_done_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (gnt[0]) begin
          rd_state_d   = RD_M0;
          last_grant_d = 1'b0;
        end else if (gnt[1]) begin
          rd_state_d   = RD_M1;
          last_grant_d = 1'b1;
        end
      end
      RD_M0, RD_M1: begin
        if (s_ar_valid_o && s_ar_ready_i) ar_done_d = 1'b1;
        if (s_r_valid_i && m_r_ready) begin
          rd_state_d = RD_IDLE;
          ar_done_d  = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write path: single outstanding LSU write, aw/w may finish in either order.
  logic wr_busy;
  assign wr_busy       = (wr_state_q == WR_BUSY);
  assign s_aw_valid_o  = wr_busy & ~aw_done_q & m1_aw_valid_i;
  assign s_aw_port_o   = wr_busy ? m1_aw_port_i : '0;
  assign s_aw_addr_o   = wr_busy ? m1_aw_addr_i : '0;
  assign m1_aw_ready_o = wr_busy & ~aw_done_q & s_aw_ready_i;
  assign s_w_valid_o   = wr_busy & ~w_done_q & m1_w_valid_i;
  assign s_w_strb_o    = wr_busy ? m1_w_strb_i : '0;
  assign s_w_data_o    = wr_busy ? m1_w_data_i : '0;
  assign m1_w_ready_o  = wr_busy & ~w_done_q & s_w_ready_i;
  assign s_b_ready_o   = wr_busy & m1_b_ready_i;
  assign m1_b_valid_o  = wr_busy & s_b_valid_i;
  assign m1_b_resp_o   = wr_busy ? s_b_resp_i : '0;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      WR_IDLE: if (m1_aw_valid_i) wr_state_d = WR_BUSY;
      WR_BUSY: begin
        if (s_aw_valid_o && s_aw_ready_i) aw_done_d = 1'b1;
        if (s_w_valid_o && s_w_ready_i)   w_done_d  = 1'b1;
        if (s_b_valid_i && m1_b_ready_i) begin
          wr_state_d = WR_IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_q   <= RD_IDLE;
      wr_state_q   <= WR_IDLE;
      last_grant_q <= 1'b1;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      last_grant_q <= last_grant_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_arbiter.sv
// Bench: behavioural SRAM slave with programmable latency, directed + random master traffic,
// expectations from a reference memory and a last-winner round-robin model.
module tb_ysyx_23060077_riscv_axi_arbiter;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic m0_ar_valid_i = 0, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i = 1;
  logic [2:0] m0_ar_port_i = 0; logic [31:0] m0_ar_addr_i = 0;
  logic [1:0] m0_r_resp_o; logic [31:0] m0_r_data_o;
  logic m1_ar_valid_i = 0, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i = 1;
  logic [2:0] m1_ar_port_i = 0; logic [31:0] m1_ar_addr_i = 0;
  logic [1:0] m1_r_resp_o; logic [31:0] m1_r_data_o;
  logic m1_aw_valid_i = 0, m1_aw_ready_o, m1_w_valid_i = 0, m1_w_ready_o;
  logic [2:0] m1_aw_port_i = 0; logic [31:0] m1_aw_addr_i = 0;
  logic [3:0] m1_w_strb_i = 0; logic [31:0] m1_w_data_i = 0;
  logic m1_b_valid_o, m1_b_ready_i = 1; logic [1:0] m1_b_resp_o;
  logic s_aw_valid_o, s_aw_ready_i; logic [2:0] s_aw_port_o; logic [31:0] s_aw_addr_o;
  logic s_w_valid_o, s_w_ready_i; logic [3:0] s_w_strb_o; logic [31:0] s_w_data_o;
  logic s_b_valid_i, s_b_ready_o; logic [1:0] s_b_resp_i;
  logic s_ar_valid_o, s_ar_ready_i; logic [2:0] s_ar_port_o; logic [31:0] s_ar_addr_o;
  logic s_r_valid_i, s_r_ready_o; logic [1:0] s_r_resp_i; logic [31:0] s_r_data_i;

  ysyx_23060077_riscv_axi_arbiter dut (
    .aclk(aclk), .areset(areset),
    .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o), .m0_ar_port_i(m0_ar_port_i),
    .m0_ar_addr_i(m0_ar_addr_i), .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i),
    .m0_r_resp_o(m0_r_resp_o), .m0_r_data_o(m0_r_data_o),
    .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o), .m1_ar_port_i(m1_ar_port_i),
    .m1_ar_addr_i(m1_ar_addr_i), .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i),
    .m1_r_resp_o(m1_r_resp_o), .m1_r_data_o(m1_r_data_o),
    .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_ready_o(m1_aw_ready_o), .m1_aw_port_i(m1_aw_port_i),
    .m1_aw_addr_i(m1_aw_addr_i), .m1_w_valid_i(m1_w_valid_i), .m1_w_ready_o(m1_w_ready_o),
    .m1_w_strb_i(m1_w_strb_i), .m1_w_data_i(m1_w_data_i), .m1_b_valid_o(m1_b_valid_o),
    .m1_b_ready_i(m1_b_ready_i), .m1_b_resp_o(m1_b_resp_o),
    .s_aw_valid_o(s_aw_valid_o), .s_aw_ready_i(s_aw_ready_i), .s_aw_port_o(s_aw_port_o),
    .s_aw_addr_o(s_aw_addr_o), .s_w_valid_o(s_w_valid_o), .s_w_ready_i(s_w_ready_i),
    .s_w_strb_o(s_w_strb_o), .s_w_data_o(s_w_data_o), .s_b_valid_i(s_b_valid_i),
    .s_b_ready_o(s_b_ready_o), .s_b_resp_i(s_b_resp_i),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i), .s_ar_port_o(s_ar_port_o),
    .s_ar_addr_o(s_ar_addr_o), .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o),
    .s_r_resp_i(s_r_resp_i), .s_r_data_i(s_r_data_i)
  );

  wire any_out = |{m0_ar_ready_o, m0_r_valid_o, m0_r_resp_o, m0_r_data_o,
                   m1_ar_ready_o, m1_r_valid_o, m1_r_resp_o, m1_r_data_o,
                   m1_aw_ready_o, m1_w_ready_o, m1_b_valid_o, m1_b_resp_o,
                   s_aw_valid_o, s_aw_port_o, s_aw_addr_o, s_w_valid_o, s_w_strb_o, s_w_data_o,
                   s_b_ready_o, s_ar_valid_o, s_ar_port_o, s_ar_addr_o, s_r_ready_o};
  wire m1_rd_any = |{m1_ar_ready_o, m1_r_valid_o, m1_r_resp_o, m1_r_data_o};

  function automatic logic [31:0] sram_init(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // ---------------- behavioural SRAM slave (always ready, queued requests) ----------------
  int rd_dly = 1, wr_dly = 1;
  logic [31:0] smem [0:63];
  logic [63:0] smem_vld = '0;
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return smem_vld[a[7:2]] ? smem[a[7:2]] : sram_init(a);
  endfunction
  assign s_ar_ready_i = 1'b1;
  assign s_aw_ready_i = 1'b1;
  assign s_w_ready_i  = 1'b1;
  logic [31:0] rq [0:7]; logic [2:0] rwp, rrp; logic r_act; int rcnt; logic [31:0] raddr;
  logic [31:0] awq [0:7]; logic [31:0] wqd [0:7]; logic [3:0] wqs [0:7];
  logic [2:0] awwp, awrp, wwp, wrp; logic b_act; int bcnt;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      rwp <= 0; rrp <= 0; r_act <= 0; rcnt <= 0; raddr <= 0;
      s_r_valid_i <= 0; s_r_data_i <= 0; s_r_resp_i <= 0;
      awwp <= 0; awrp <= 0; wwp <= 0; wrp <= 0; b_act <= 0; bcnt <= 0;
      s_b_valid_i <= 0; s_b_resp_i <= 0;
    end else begin
      if (s_ar_valid_o) begin rq[rwp] <= s_ar_addr_o; rwp <= rwp + 3'd1; end
      if (!r_act && rwp != rrp) begin
        r_act <= 1; rcnt <= rd_dly; raddr <= rq[rrp]; rrp <= rrp + 3'd1;
      end else if (r_act && !s_r_valid_i) begin
        if (rcnt <= 1) begin s_r_valid_i <= 1; s_r_data_i <= slv_rd(raddr); end
        else rcnt <= rcnt - 1;
      end else if (s_r_valid_i && s_r_ready_o) begin
        s_r_valid_i <= 0; s_r_data_i <= 0; r_act <= 0;
      end
      if (s_aw_valid_o) begin awq[awwp] <= s_aw_addr_o; awwp <= awwp + 3'd1; end
      if (s_w_valid_o) begin wqd[wwp] <= s_w_data_o; wqs[wwp] <= s_w_strb_o; wwp <= wwp + 3'd1; end
      if (!b_act && awwp != awrp && wwp != wrp) begin
        smem[awq[awrp][7:2]] <= merge(slv_rd(awq[awrp]), wqd[wrp], wqs[wrp]);
        smem_vld[awq[awrp][7:2]] <= 1'b1;
        b_act <= 1; bcnt <= wr_dly; awrp <= awrp + 3'd1; wrp <= wrp + 3'd1;
      end else if (b_act && !s_b_valid_i) begin
        if (bcnt <= 1) s_b_valid_i <= 1; else bcnt <= bcnt - 1;
      end else if (s_b_valid_i && s_b_ready_o) begin
        s_b_valid_i <= 0; b_act <= 0;
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, m0_beats = 0, m1_beats = 0, ar_hs = 0, aw_hs = 0, w_hs = 0, m1_noise = 0;
  bit m1_quiet_en = 0;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (m0_r_valid_o && m0_r_ready_i) m0_beats <= m0_beats + 1;
    if (m1_r_valid_o && m1_r_ready_i) m1_beats <= m1_beats + 1;
    if (s_ar_valid_o && s_ar_ready_i) ar_hs <= ar_hs + 1;
    if (s_aw_valid_o && s_aw_ready_i) aw_hs <= aw_hs + 1;
    if (s_w_valid_o && s_w_ready_i) w_hs <= w_hs + 1;
  end
  always @(negedge aclk) if (m1_quiet_en && m1_rd_any) m1_noise <= m1_noise + 1;

  // ---------------- checking + reference model ----------------
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] ref_mem [logic [31:0]];
  bit ref_last = 1'b1;
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : sram_init(a);
  endfunction

  task automatic rd(input int m, input logic [31:0] a, input bit hold,
                    output logic [31:0] d, output int t_ar, output int t_r);
    int n;
    d = 0;
    if (m == 0) begin m0_ar_valid_i = 1; m0_ar_addr_i = a; m0_ar_port_i = 3'd4; end
    else        begin m1_ar_valid_i = 1; m1_ar_addr_i = a; m1_ar_port_i = 3'd1; end
    t_ar = -1; n = 0;
    while (t_ar < 0 && n < 300) begin
      @(negedge aclk); n++;
      if ((m == 0) ? m0_ar_ready_o : m1_ar_ready_o) begin
        t_ar = cyc;
        chk("s_ar_addr", 64'(s_ar_addr_o), 64'(a));
      end
    end
    chk("ar_grant_timeout", 64'(t_ar >= 0), 64'(1));
    @(posedge aclk); #1;
    if (!hold) begin if (m == 0) m0_ar_valid_i = 0; else m1_ar_valid_i = 0; end
    t_r = -1; n = 0;
    while (t_r < 0 && n < 300) begin
      @(negedge aclk); n++;
      if ((m == 0) ? m0_r_valid_o : m1_r_valid_o) begin
        t_r = cyc; d = (m == 0) ? m0_r_data_o : m1_r_data_o;
      end
    end
    chk("r_timeout", 64'(t_r >= 0), 64'(1));
    @(posedge aclk); #1;
    if (m == 0) m0_ar_valid_i = 0; else m1_ar_valid_i = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, input bit poke, output logic [1:0] resp, output int t_b);
    int n;
    ref_mem[a] = merge(ref_rd(a), d, s);
    fork
      begin
        int k; bit ok;
        m1_w_valid_i = 1; m1_w_data_i = d; m1_w_strb_i = s; ok = 0; k = 0;
        while (!ok && k < 300) begin @(negedge aclk); k++; ok = m1_w_ready_o; end
        chk("w_timeout", 64'(ok), 64'(1));
        @(posedge aclk); #1; m1_w_valid_i = 0;
      end
      begin
        int k; bit ok;
        repeat (w_lead) @(posedge aclk);
        if (w_lead > 0) #1;
        m1_aw_valid_i = 1; m1_aw_addr_i = a; m1_aw_port_i = 3'd2; ok = 0; k = 0;
        while (!ok && k < 300) begin @(negedge aclk); k++; ok = m1_aw_ready_o; end
        chk("aw_timeout", 64'(ok), 64'(1));
        chk("s_aw_addr", 64'(s_aw_addr_o), 64'(a));
        @(posedge aclk); #1; m1_aw_valid_i = 0;
      end
    join
    if (poke) begin
      m1_aw_valid_i = 1;
      @(negedge aclk);
      chk("aw_ready_busy", 64'(m1_aw_ready_o), 64'(0));
      chk("s_aw_valid_busy", 64'(s_aw_valid_o), 64'(0));
      @(posedge aclk); #1; m1_aw_valid_i = 0;
    end
    t_b = -1; n = 0; resp = 2'b11;
    while (t_b < 0 && n < 300) begin
      @(negedge aclk); n++;
      if (m1_b_valid_o) begin t_b = cyc; resp = m1_b_resp_o; end
    end
    chk("b_timeout", 64'(t_b >= 0), 64'(1));
    @(posedge aclk); #1;
  endtask

  // Both masters request on the same cycle from idle; model predicts the winner.
  task automatic collide(input string tag, input logic [31:0] a0, input logic [31:0] a1);
    logic [31:0] d0, d1; int ta0, tr0, ta1, tr1; int first;
    first = ref_last ? 0 : 1;
    fork
      rd(0, a0, 0, d0, ta0, tr0);
      rd(1, a1, 0, d1, ta1, tr1);
    join
    chk({tag, "_winner"}, 64'((ta0 < ta1) ? 0 : 1), 64'(first));
    chk({tag, "_gap"}, 64'((first == 0) ? ta1 - tr0 : ta0 - tr1), 64'(2));
    chk({tag, "_d0"}, 64'(d0), 64'(ref_rd(a0)));
    chk({tag, "_d1"}, 64'(d1), 64'(ref_rd(a1)));
    ref_last = (first == 0);
  endtask

  initial begin
    logic [31:0] d; logic [1:0] resp; int ta, tr, tb, b0, h0, h1;
    logic [31:0] ra0, ra1;
    #1;
    chk("reset_outputs", 64'(any_out), 64'(0));
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(negedge aclk);
    chk("idle_outputs", 64'(any_out), 64'(0));
    @(posedge aclk); #1;

    // single IFU read, slave latency 5
    rd_dly = 5; m1_quiet_en = 1; b0 = m0_beats;
    rd(0, 32'h8000_0000, 0, d, ta, tr);
    repeat (3) @(posedge aclk);
    m1_quiet_en = 0;
    chk("ifu_data", 64'(d), 64'h0000_0000_DEAD_BEEF);
    chk("ifu_one_beat", 64'(m0_beats - b0), 64'(1));
    chk("m1_quiet", 64'(m1_noise), 64'(0));
    ref_last = 0;

    // collisions: M0 then M1, then after a lone M0 read the order flips
    areset = 1; #1; @(posedge aclk); #1 areset = 0; ref_last = 1;
    rd_dly = 2;
    collide("coll_a", 32'h8000_0020, 32'h8000_0024);
    rd(0, 32'h8000_0028, 0, d, ta, tr); ref_last = 0;
    collide("coll_b", 32'h8000_002C, 32'h8000_0030);

    // LSU write, w leads aw by 2 cycles, second aw while busy
    wr_dly = 6; h0 = aw_hs; h1 = w_hs;
    wr(32'h8000_0010, 32'h1234_5678, 4'hF, 2, 1, resp, tb);
    chk("wr1_resp", 64'(resp), 64'(0));
    chk("wr1_aw_once", 64'(aw_hs - h0), 64'(1));
    chk("wr1_w_once", 64'(w_hs - h1), 64'(1));
    rd(1, 32'h8000_0010, 0, d, ta, tr); ref_last = 1;
    chk("wr1_readback", 64'(d), 64'(ref_rd(32'h8000_0010)));

    // aw and w same cycle
    wr_dly = 2; h0 = aw_hs; h1 = w_hs;
    wr(32'h8000_0010, 32'h1234_5678, 4'hF, 0, 0, resp, tb);
    chk("wr2_resp", 64'(resp), 64'(0));
    chk("wr2_w_once", 64'(w_hs - h1), 64'(1));

    // master holds ar_valid until r: exactly one request reaches the slave
    rd_dly = 4; h0 = ar_hs;
    rd(0, 32'h8000_0004, 1, d, ta, tr); ref_last = 0;
    chk("hold_ar_once", 64'(ar_hs - h0), 64'(1));
    chk("hold_data", 64'(d), 64'(ref_rd(32'h8000_0004)));

    // concurrent read (3) and write (7)
    rd_dly = 3; wr_dly = 7;
    fork
      rd(0, 32'h8000_0008, 0, d, ta, tr);
      wr(32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, resp, tb);
    join
    ref_last = 0;
    chk("conc_rdata", 64'(d), 64'(ref_rd(32'h8000_0008)));
    chk("conc_bresp", 64'(resp), 64'(0));
    chk("conc_rd_first", 64'(tr < tb), 64'(1));

    // randomized traffic against the reference model
    for (int it = 0; it < 16; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rd_dly = $urandom_range(0, 4); wr_dly = $urandom_range(1, 4);
      ra0 = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      ra1 = 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        wr(ra1, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), 0, resp, tb);
        chk("rnd_bresp", 64'(resp), 64'(0));
      end
      if (pat == 3) collide("rnd_coll", ra0, ra1);
      else begin
        rd(pat - 1, (pat == 1) ? ra0 : ra1, 0, d, ta, tr);
        chk("rnd_rdata", 64'(d), 64'(ref_rd((pat == 1) ? ra0 : ra1)));
        ref_last = (pat == 2);
      end
    end

    // async reset while M1 waits for r
    rd_dly = 10; b0 = m1_beats;
    m1_ar_valid_i = 1; m1_ar_addr_i = 32'h8000_0044; m1_ar_port_i = 3'd1;
    tr = 0;
    for (int k = 0; k < 100 && tr == 0; k++) begin @(negedge aclk); tr = int'(m1_ar_ready_o); end
    chk("rst_pre_grant", 64'(tr), 64'(1));
    @(posedge aclk); #1 m1_ar_valid_i = 0;
    @(negedge aclk);
    chk("rst_pre_r_ready", 64'(s_r_ready_o), 64'(1));
    #1 areset = 1;
    #1 chk("rst_async_outputs", 64'(any_out), 64'(0));
    @(posedge aclk); #1 areset = 0; ref_last = 1;
    repeat (14) @(posedge aclk);
    chk("rst_no_stale_r", 64'(m1_beats - b0), 64'(0));
    rd_dly = 2; #1;
    rd(0, 32'h8000_0000, 0, d, ta, tr);
    chk("rst_fresh_read", 64'(d), 64'(ref_rd(32'h8000_0000)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
